// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial-loaded instruction memory.
// Holds the loader FSM encoding, the fetch-side NOP and default geometry.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam int unsigned DefDepth = 64;
  localparam int unsigned DefAw    = 6;

endpackage

// File: rtl/imem_word_deserializer.sv
// Serial-to-parallel word assembler, MSB first. Pulses word_valid on the cycle
// that carries the last bit of a word, with the complete word presented alongside.
module imem_word_deserializer
  import imem_loader_pkg::*;
#(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         ser_valid,
  input  logic         ser_in,
  output logic         word_valid,
  output logic [n-1:0] word
);

  localparam int unsigned CW = $clog2(n);

  // Only n-1 bits need storing: the n-th bit goes straight to the output.
  logic [n-2:0]  shift_q, shift_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_bit;

  assign last_bit   = (cnt_q == CW'(n - 1));
  assign word_valid = ser_valid && !clear && last_bit;
  assign word       = {shift_q, ser_in};

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (ser_valid) begin
      shift_d = {shift_q[n-3:0], ser_in};
      cnt_d   = last_bit ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_shift_loader.sv
// Instruction memory filled from a serial bit stream before the core runs.
// Fetches return NOP until the whole image is resident, and for out-of-range PCs.
module imem_shift_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned n     = 32,
  parameter int unsigned DEPTH = DefDepth,
  parameter int unsigned AW    = DefAw
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_start,
  input  logic         ser_valid,
  input  logic         ser_in,
  input  logic [n-1:0] pc_to_imem,
  output logic [n-1:0] imem_out,
  output logic         shift_done,
  output logic         load_busy,
  output logic [AW:0]  words_loaded
);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   words_q, words_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [n-1:0]  mem_q [DEPTH];

  logic          shift_en;
  logic          word_valid;
  logic [n-1:0]  word;
  logic          unused_pc_lsb;

  // load_start wins over a valid bit in the same cycle; that bit is dropped.
  assign shift_en = (state_q == StShift) && ser_valid && !load_start;

  imem_word_deserializer #(
    .n(n)
  ) u_deser (
    .clk       (clk),
    .rst       (rst),
    .clear     (load_start),
    .ser_valid (shift_en),
    .ser_in    (ser_in),
    .word_valid(word_valid),
    .word      (word)
  );

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    words_d = words_q;
    done_d  = done_q;
    busy_d  = busy_q;
    if (load_start) begin
      state_d = StShift;
      wptr_d  = '0;
      words_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else if (word_valid) begin
      wptr_d = wptr_q + 1'b1;
      if (words_q != (AW + 1)'(DEPTH)) begin
        words_d = words_q + 1'b1;
      end
      if (wptr_q == AW'(DEPTH - 1)) begin
        state_d = StDone;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      words_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      words_q <= words_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Array contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem_q[wptr_q] <= word;
    end
  end

  always_comb begin
    imem_out = n'(NopInstr);
    if (done_q && (pc_to_imem[n-1:AW+2] == '0)) begin
      imem_out = mem_q[pc_to_imem[AW+1:2]];
    end
  end

  assign unused_pc_lsb = ^pc_to_imem[1:0];

  assign shift_done   = done_q;
  assign load_busy    = busy_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_shift_loader.sv
// Self-checking bench for imem_shift_loader with a small 4-word array.
// Directed load/restart/reset sequences plus random traffic against a queue-based model.
module tb_imem_shift_loader;

  localparam int N     = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_start = 1'b0;
  logic          ser_valid = 1'b0;
  logic          ser_in = 1'b0;
  logic [N-1:0]  pc_to_imem = '0;
  logic [N-1:0]  imem_out;
  logic          shift_done;
  logic          load_busy;
  logic [AW:0]   words_loaded;

  imem_shift_loader #(
    .n    (N),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_start  (load_start),
    .ser_valid   (ser_valid),
    .ser_in      (ser_in),
    .pc_to_imem  (pc_to_imem),
    .imem_out    (imem_out),
    .shift_done  (shift_done),
    .load_busy   (load_busy),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bits collected since the last load_start, packed once 32 arrive.
  bit          m_loading;
  bit          m_done;
  int          m_words;
  bit          m_bits[$];
  logic [31:0] m_mem [DEPTH];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t     vec [8];
  logic [31:0] img [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] pc);
    if (m_done && pc < 32'(DEPTH * 4)) return m_mem[pc[AW+1:2]];
    return NOP;
  endfunction

  task automatic model_reset();
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_words   = 0;
    m_bits.delete();
  endtask

  task automatic model_update(input bit ls, input bit v, input bit b);
    logic [31:0] w;
    if (!rst) begin
      model_reset();
    end else if (ls) begin
      m_loading = 1'b1;
      m_done    = 1'b0;
      m_words   = 0;
      m_bits.delete();
    end else if (m_loading && v) begin
      m_bits.push_back(b);
      if (m_bits.size() == N) begin
        w = '0;
        for (int i = 0; i < N; i++) w = w * 2 + 32'(m_bits[i]);
        m_mem[m_words] = w;
        m_words++;
        m_bits.delete();
        if (m_words == DEPTH) begin
          m_loading = 1'b0;
          m_done    = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".shift_done"}, 32'(shift_done), 32'(m_done));
    chk({tag, ".load_busy"}, 32'(load_busy), 32'(m_loading));
    chk({tag, ".words_loaded"}, 32'(words_loaded), 32'(m_words));
    chk({tag, ".imem_out"}, imem_out, exp_read(pc_to_imem));
  endtask

  // One clock: drive inputs, let the edge happen, update model, check #1 later.
  task automatic cyc(input bit ls, input bit v, input bit b, input logic [31:0] pc);
    load_start = ls;
    ser_valid  = v;
    ser_in     = b;
    pc_to_imem = pc;
    @(posedge clk);
    model_update(ls, v, b);
    #1;
    check_outputs("cyc");
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return 32'($urandom_range(0, 31));
  endfunction

  task automatic load_words(input bit use_ff, input bit gapped);
    int          gap_cnt;
    logic [31:0] w;
    gap_cnt = 0;
    for (int k = 0; k < DEPTH; k++) begin
      w = use_ff ? 32'hFFFF_FFFF : img[k];
      for (int i = 31; i >= 0; i--) begin
        if (gapped) begin
          if (gap_cnt % 3 == 2) begin
            cyc(1'b0, 1'b0, 1'($urandom), rand_pc());
            gap_cnt++;
          end
          gap_cnt++;
        end
        cyc(1'b0, 1'b1, w[i], rand_pc());
      end
    end
  endtask

  task automatic run_vectors(input string tag);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 1'b0, vec[i].pc);
      chk(tag, imem_out, vec[i].exp);
    end
  endtask

  initial begin
    img = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3, 32'h0000_0063};
    vec = '{
      '{32'h0000_0008, 32'h0020_81B3},
      '{32'h0000_0007, 32'h00A0_0113},
      '{32'h0000_0010, NOP},
      '{32'h0000_0000, 32'h0050_0093},
      '{32'h0000_000C, 32'h0000_0063},
      '{32'h0000_0005, 32'h00A0_0113},
      '{32'h8000_0000, NOP},
      '{32'h0000_000E, 32'h0000_0063}
    };
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    model_reset();

    // Reset state
    #2;
    chk("reset.shift_done", 32'(shift_done), 32'd0);
    chk("reset.load_busy", 32'(load_busy), 32'd0);
    chk("reset.words_loaded", 32'(words_loaded), 32'd0);
    chk("reset.imem_out", imem_out, NOP);
    #6 rst = 1'b1;
    @(posedge clk);
    #1;

    // ser_valid in IDLE is ignored; pre-load read is a NOP
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    chk("preload_nop", imem_out, NOP);
    chk("idle_words", 32'(words_loaded), 32'd0);

    // Full contiguous load
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("start_busy", 32'(load_busy), 32'd1);
    load_words(1'b0, 1'b0);
    chk("full.shift_done", 32'(shift_done), 32'd1);
    chk("full.words_loaded", 32'(words_loaded), 32'd4);
    chk("full.load_busy", 32'(load_busy), 32'd0);
    run_vectors("full.read");

    // Gapped stream gives the same contents
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("gap.restart_done", 32'(shift_done), 32'd0);
    load_words(1'b0, 1'b1);
    chk("gap.shift_done", 32'(shift_done), 32'd1);
    run_vectors("gap.read");

    // Restart mid-word: the bit sent with load_start is dropped
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, 1'($urandom), rand_pc());
    chk("mid.words_before", 32'(words_loaded), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 32'h0);
    chk("mid.words_cleared", 32'(words_loaded), 32'd0);
    chk("mid.busy", 32'(load_busy), 32'd1);
    load_words(1'b0, 1'b0);
    chk("mid.shift_done", 32'(shift_done), 32'd1);
    run_vectors("mid.read");

    // Asynchronous reset after two words
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 64; i++) cyc(1'b0, 1'b1, 1'($urandom), rand_pc());
    chk("rstmid.words_before", 32'(words_loaded), 32'd2);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("rstmid.shift_done", 32'(shift_done), 32'd0);
    chk("rstmid.load_busy", 32'(load_busy), 32'd0);
    chk("rstmid.words_loaded", 32'(words_loaded), 32'd0);
    chk("rstmid.imem_out", imem_out, NOP);
    cyc(1'b0, 1'b1, 1'b1, 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 32'h4);
    rst = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 32'h8);
    chk("rstmid.nop_after", imem_out, NOP);
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    load_words(1'b0, 1'b0);
    run_vectors("rstmid.read");

    // Reload from DONE with an all-ones image
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    chk("reload.shift_done", 32'(shift_done), 32'd0);
    chk("reload.nop", imem_out, NOP);
    load_words(1'b1, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 32'(k * 4));
      chk("reload.read", imem_out, 32'hFFFF_FFFF);
    end

    // Random traffic against the model
    cyc(1'b1, 1'b0, 1'b0, 32'h0);
    for (int c = 0; c < 3000; c++) begin
      cyc(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom), rand_pc());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
